// File: rtl/spi_mem_loader_pkg.sv
// Shared types and frame-geometry helpers for the serial memory loader.
package spi_mem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam logic CMD_WRITE = 1'b1;
    localparam logic CMD_READ  = 1'b0;

    function automatic int clog2(input int value);
        int r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < value) r = i + 1;
        return r;
    endfunction

    // cmd bit + address + data
    function automatic int wr_len(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

    // a read carries one extra turnaround bit before the data phase
    function automatic int rd_len(input int addr_w, input int data_w);
        return wr_len(addr_w, data_w) + 1;
    endfunction

endpackage

// File: rtl/spi_mem_loader_if.sv
// Memory-side port bundle: one-hot write/read strobes, address, write data
// and the flattened asynchronous read data of every target.
interface spi_mem_loader_if #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int N_TARGETS = 2
);
    logic [N_TARGETS-1:0]        mem_wr_en;
    logic [N_TARGETS-1:0]        mem_rd_en;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [N_TARGETS*DATA_W-1:0] mem_rdata;

    modport master (output mem_wr_en, mem_rd_en, mem_addr, mem_wdata, input mem_rdata);
    modport slave  (input mem_wr_en, mem_rd_en, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/spi_mem_loader_shift_reg.sv
// MSB-first shift register with parallel load (load wins over shift).
module loader_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             ser,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] q,
    output logic             msb
);
    always_ff @(posedge clk) begin
        if (rst)           q <= '0;
        else if (load)     q <= load_data;
        else if (shift_en) q <= {q[WIDTH-2:0], ser};
    end

    assign msb = q[WIDTH-1];
endmodule

// File: rtl/spi_mem_loader.sv
// Framed one-bit-per-clock loader: writes and reads back N_TARGETS memories
// selected by active-low chip selects, with frame checking and a processor lock.
module spi_mem_loader
    import spi_mem_loader_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int N_TARGETS = 2,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_TARGETS-1:0] cs_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 miso_oe,
    input  logic                 lock_in,
    spi_mem_loader_if.master     mem,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic [CNT_W-1:0]     ok_cnt
);
    localparam int WR_LEN = wr_len(ADDR_W, DATA_W);
    localparam int RD_LEN = rd_len(ADDR_W, DATA_W);
    localparam int BC_W   = clog2(RD_LEN);
    localparam logic [BC_W-1:0] ADDR_LAST = BC_W'(ADDR_W);
    localparam logic [BC_W-1:0] TURN      = BC_W'(ADDR_W + 1);
    localparam logic [BC_W-1:0] WR_LAST   = BC_W'(WR_LEN - 1);
    localparam logic [BC_W-1:0] RD_LAST   = BC_W'(RD_LEN - 1);

    state_t               state_q, state_d;
    logic [BC_W-1:0]      cnt_q, cnt_d;
    logic [N_TARGETS-1:0] sel_q, sel_d, wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic                 cmd_q, cmd_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d, rdata_sel, tx_data;
    logic                 oe_q, oe_d, done_d, err_d;
    logic [CNT_W-1:0]     ok_d;
    logic                 any_low, one_low, same_sel, start;
    logic                 rx_shift, tx_shift, tx_load;
    logic [WR_LEN-2:0]    rx_q;
    logic [WR_LEN-1:0]    frame;
    logic [DATA_W-1:0]    tx_unused;
    logic                 rx_msb_unused, frame_unused;

    assign any_low  = |(~cs_n);
    assign one_low  = $onehot(~cs_n);
    assign same_sel = (cs_n == ~sel_q);
    // the bit on mosi this cycle completes the word held in the rx shifter
    assign frame        = {rx_q, mosi};
    assign frame_unused = frame[WR_LEN-1];

    loader_shift_reg #(.WIDTH(WR_LEN - 1)) rx_shifter (
        .clk, .rst, .shift_en(rx_shift), .ser(mosi), .load(1'b0),
        .load_data('0), .q(rx_q), .msb(rx_msb_unused)
    );

    // tx drains with zeros, so miso idles low once the data phase is over
    loader_shift_reg #(.WIDTH(DATA_W)) tx_shifter (
        .clk, .rst, .shift_en(tx_shift), .ser(1'b0), .load(tx_load),
        .load_data(tx_data), .q(tx_unused), .msb(miso)
    );

    always_comb begin
        rdata_sel = '0;
        for (int k = 0; k < N_TARGETS; k++)
            if (sel_q[k]) rdata_sel = rdata_sel | mem.mem_rdata[k*DATA_W +: DATA_W];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        cmd_d    = cmd_q;
        wr_en_d  = '0;
        rd_en_d  = '0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        oe_d     = oe_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        start    = 1'b0;
        rx_shift = 1'b0;
        tx_shift = 1'b0;
        tx_load  = 1'b0;
        tx_data  = '0;
        case (state_q)
            IDLE: start = 1'b1;
            RECV: begin
                if (cnt_q == '0) begin
                    start = 1'b1;
                end else if (!any_low || !same_sel) begin
                    // aborted mid-frame: no strobes, clear any pending read-out
                    err_d   = 1'b1;
                    state_d = any_low ? DISCARD : IDLE;
                    cnt_d   = '0;
                    oe_d    = 1'b0;
                    tx_load = 1'b1;
                end else begin
                    rx_shift = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cmd_q == CMD_WRITE && cnt_q == WR_LAST) begin
                        cnt_d   = '0;
                        wr_en_d = sel_q;
                        addr_d  = frame[DATA_W +: ADDR_W];
                        wdata_d = frame[DATA_W-1:0];
                        done_d  = 1'b1;
                    end
                    if (cmd_q == CMD_READ) begin
                        if (cnt_q == ADDR_LAST) begin
                            rd_en_d = sel_q;
                            addr_d  = frame[ADDR_W-1:0];
                        end
                        if (cnt_q == TURN) begin
                            tx_load = 1'b1;
                            tx_data = rdata_sel;
                            oe_d    = 1'b1;
                        end
                        if (cnt_q > TURN) tx_shift = 1'b1;
                        if (cnt_q == RD_LAST) begin
                            cnt_d  = '0;
                            oe_d   = 1'b0;
                            done_d = 1'b1;
                        end
                    end
                end
            end
            DISCARD: if (!any_low) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // frame start, both from IDLE and at a back-to-back frame boundary
        if (start) begin
            if (!any_low) begin
                state_d = IDLE;
            end else if (!one_low || lock_in) begin
                err_d   = 1'b1;
                state_d = DISCARD;
            end else begin
                state_d  = RECV;
                sel_d    = ~cs_n;
                cmd_d    = mosi;
                rx_shift = 1'b1;
                cnt_d    = BC_W'(1);
            end
        end

        ok_d = (done_d && ok_cnt != '1) ? ok_cnt + 1'b1 : ok_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= any_low ? DISCARD : IDLE;
            cnt_q      <= '0;
            sel_q      <= '0;
            cmd_q      <= 1'b0;
            wr_en_q    <= '0;
            rd_en_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            oe_q       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            ok_cnt     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            cmd_q      <= cmd_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            oe_q       <= oe_d;
            frame_done <= done_d;
            frame_err  <= err_d;
            ok_cnt     <= ok_d;
        end
    end

    assign mem.mem_wr_en = wr_en_q;
    assign mem.mem_rd_en = rd_en_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign miso_oe       = oe_q;
endmodule

// File: doc/spi_mem_loader.md
Name: spi_mem_loader

Overview:
Parametrised serial slave that loads and reads back N_TARGETS on-chip memories (icache, dcache, future register files) over a one-bit-per-clk MOSI/MISO link with per-target active-low chip selects. It replaces the fixed 12-bit write-only buffer with framed read and write commands, bit counting, frame-error detection and a lock against processor execution. It sits between the uio pins and the memory write/read ports.

Parameters:
DATA_W, 8, memory word width
ADDR_W, 4, memory address width
N_TARGETS, 2, number of selectable memories (chip selects)
CNT_W, 8, width of saturating good-frame counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cs_n  in  N_TARGETS  per-target chip select, active low, legal only one-hot-low or all-high
mosi  in  1  serial data in, sampled on every clk edge while a target is selected
miso  out  1  serial read data, registered
miso_oe  out  1  high during read data phase
lock_in  in  1  processor executing; blocks new frames
mem_wr_en  out  N_TARGETS  one-hot write strobe, one cycle
mem_rd_en  out  N_TARGETS  one-hot read strobe, one cycle
mem_addr  out  ADDR_W  registered address
mem_wdata  out  DATA_W  registered write data
mem_rdata  in  N_TARGETS*DATA_W  asynchronous read data, target k at [k*DATA_W +: DATA_W]
frame_done  out  1  one-cycle pulse per good frame
frame_err  out  1  one-cycle pulse per aborted or illegal frame
ok_cnt  out  CNT_W  saturating count of good frames

Behaviour:
- Reset: all outputs 0; state goes to DISCARD if any cs_n is low at reset release, otherwise IDLE. An in-flight frame is dropped without strobes.
- Frame, MSB first: bit 0 = cmd (1 = write, 0 = read), then ADDR_W address bits.
- Write frame: then DATA_W data bits; WR_LEN = 1+ADDR_W+DATA_W.
- Read frame: then 1 turnaround bit, then DATA_W data bits (mosi ignored); RD_LEN = WR_LEN+1.
- States:
  - IDLE: all cs_n high. Exactly one low and lock_in=0: capture bit 0, latch target index, go to RECV with bit counter = 1.
  - IDLE, lock_in=1 with a select: go to DISCARD, pulse frame_err.
  - IDLE, multiple cs_n low: go to DISCARD, pulse frame_err.
  - RECV: capture one bit per cycle.
  - DISCARD: ignore all input; go to IDLE when all cs_n high; no further error pulses.
- Write commit: the cycle after the last data bit is captured, assert mem_wr_en[target], mem_addr and mem_wdata for exactly one cycle, and pulse frame_done.
- Read:
  - In the turnaround cycle, assert mem_rd_en[target] with mem_addr valid.
  - Load mem_rdata of the target into the tx register at that edge.
  - For data cycles 0..DATA_W-1, miso = tx bit DATA_W-1-j and miso_oe=1.
  - frame_done pulses the cycle after the last data cycle.
  - miso and miso_oe return to 0 outside data cycles.
- Back-to-back frames: the counter wraps to 0 at frame end. If the same cs_n stays low, the next cycle is bit 0 of a new frame. Commit strobes overlap the new frame's first bit; the shift register is independent of the committed address/data registers.
- Deselect:
  - All cs_n high with counter = 0: clean, go to IDLE.
  - With counter ≠ 0: pulse frame_err, no strobes, go to IDLE.
- Select change mid-frame (different or extra cs_n low): pulse frame_err, go to DISCARD.
- lock_in gates only frame start. A frame already in RECV completes normally.
- ok_cnt increments on frame_done and saturates at all-ones.
- frame_done and frame_err never pulse in the same cycle for the same frame.

Decomposition:
- Package spi_mem_loader_pkg:
  - state enum IDLE/RECV/DISCARD
  - WR_LEN/RD_LEN derivation functions
  - CMD_WRITE/CMD_READ constants
  - clog2 function replacing the CLOG2 macro
- Sub-module loader_shift_reg: parametrised width, shift enable, serial in, parallel out, parallel load, serial out. Instantiated twice, once as the rx shifter and once as the tx shifter.
- The FSM and counter stay in the top.

Test Plan (DATA_W=8, ADDR_W=4, N_TARGETS=2):
1. cs_n=2'b10, bits 1,0011,10100101 -> one cycle later mem_wr_en=2'b01, mem_addr=3, mem_wdata=A5, frame_done=1, ok_cnt=1.
2. mem_rdata[15:8]=3C, cs_n=2'b01, bits 0,0111,x,8×x -> mem_rd_en=2'b10 at turnaround; miso streams 0,0,1,1,1,1,0,0 with miso_oe=1; frame_done after the last data cycle.
3. Two write frames back-to-back on cs_n=2'b10 (addr 1/data 11, addr 2/data 22) -> two wr strobes 13 cycles apart, ok_cnt=2.
4. Deselect after 6 bits -> frame_err=1, no mem_wr_en. cs_n=2'b00 -> frame_err once, DISCARD until 2'b11.
5. lock_in=1 at frame start -> frame_err, nothing written. lock_in rising mid-frame -> frame completes, write occurs.
6. rst at bit 7 with cs_n still low -> no strobes, DISCARD. After deselect, a fresh frame succeeds. 256 good frames -> ok_cnt holds FF.
